// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide unit for the execute stage. Takes the two
//   register-file read operands, runs one operation at a time with one
//   iteration per enabled clock, and hands the result plus write-back
//   controls to the register-file write port.
//
//   Sequence: IDLE -> RUN (WIDTH iterations + one finalize edge) -> DONE -> IDLE.
//   A start accepted at edge k shows done after edge k+WIDTH+1. Divide by
//   zero skips the iterations and shows done after edge k+1.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset, overrides EN
//   EN        in   stage enable; 0 freezes all state
//   start     in   request, sampled only in IDLE with EN=1
//   op[1:0]   in   00 MUL lo, 01 MUL hi, 10 DIV quotient, 11 DIV remainder
//   opA       in   multiplicand / dividend
//   opB       in   multiplier / divisor
//   dest      in   destination register select, captured with start
//   sgn       in   (SIGNED_OP_EN only) two's complement operands, captured
//   busy      out  operation in flight (through the done cycle)
//   done      out  result valid (held while EN=0 in DONE)
//   result    out  result, held until the next operation finishes
//   wb_sel    out  captured dest
//   wb_write  out  write strobe, done qualified by wb_sel != 0
//
// Optional feature macro: SIGNED_OP_EN
//   Adds port sgn. Iterations run on magnitudes; sign fix-up is applied on
//   the finalize edge so latency is unchanged.
// ----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [SEL_W-1:0] dest,
`ifdef SIGNED_OP_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [SEL_W-1:0] wb_sel,
    output logic             wb_write
);

    localparam int CW = $clog2(WIDTH) + 1;
    // Counter value at which the iterations are complete and the result is
    // latched on the way into DONE.
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // MUL: {partial product hi, multiplier/product lo}.
    // DIV: {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               dz_q, dz_d;
    // neg_q negates product/quotient, negr_q negates remainder.
    logic               neg_q, neg_d;
    logic               negr_q, negr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SEL_W-1:0]   wb_sel_q, wb_sel_d;

    // ------------------------------------------------------------------
    // Operand conditioning at accept
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             neg_cap, negr_cap;

`ifdef SIGNED_OP_EN
    assign mag_a    = (sgn && opA[WIDTH-1]) ? -opA : opA;
    assign mag_b    = (sgn && opB[WIDTH-1]) ? -opB : opB;
    assign neg_cap  = sgn & (opA[WIDTH-1] ^ opB[WIDTH-1]);
    assign negr_cap = sgn & opA[WIDTH-1];
`else
    assign mag_a    = opA;
    assign mag_b    = opB;
    assign neg_cap  = 1'b0;
    assign negr_cap = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole 2W+1 result right by one.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

    // Restoring divide: the W+1 bit partial remainder is the current
    // remainder shifted left with the next dividend bit brought in.
    logic [WIDTH:0] rem_sh;
    logic           rem_ge;
    logic [WIDTH-1:0] rem_nxt;
    assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_ge  = (rem_sh >= {1'b0, opnd_q});
    // After a successful subtract the difference is below the divisor, so
    // the low W bits are the whole remainder.
    assign rem_nxt = rem_ge ? WIDTH'(rem_sh - {1'b0, opnd_q}) : rem_sh[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Finalize: sign fix-up and result select
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fin_res;

    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        fin_res = '0;
        case (op_q)
            2'b00: fin_res = prod_fix[WIDTH-1:0];
            2'b01: fin_res = prod_fix[2*WIDTH-1:WIDTH];
            // Divide by zero: quotient all ones regardless of signs.
            2'b10: fin_res = dz_q ? {WIDTH{1'b1}} : quo_fix;
            // Divide by zero keeps the raw dividend in the high half.
            default: fin_res = dz_q ? acc_q[2*WIDTH-1:WIDTH] : rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        dz_d     = dz_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        result_d = result_q;
        wb_sel_d = wb_sel_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    op_d     = op;
                    wb_sel_d = dest;
                    neg_d    = neg_cap;
                    negr_d   = negr_cap;
                    dz_d     = op[1] && (opB == '0);
                    cnt_d    = '0;
                    if (op[1]) begin
                        opnd_d = mag_b;
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                    end
                    if (op[1] && (opB == '0)) begin
                        // Skip the iterations: next edge finalizes.
                        cnt_d = LAST;
                        acc_d = {opA, {WIDTH{1'b0}}};
                    end
                end
            end

            S_RUN: begin
                if (cnt_q == LAST) begin
                    result_d = fin_res;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q[1])
                        acc_d = {rem_nxt, acc_q[WIDTH-2:0], rem_ge};
                    else
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            dz_q     <= 1'b0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            wb_sel_q <= '0;
        end else if (EN) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            dz_q     <= dz_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            wb_sel_q <= wb_sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    // Register 0 is never written.
    assign wb_write = done && (wb_sel_q != '0);
    assign result   = result_q;
    assign wb_sel   = wb_sel_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    localparam int W = 32;
    localparam int S = 5;

    logic         clk = 1'b0;
    logic         rst, EN, start;
    logic [1:0]   op;
    logic [W-1:0] opA, opB;
    logic [S-1:0] dest;
`ifdef SIGNED_OP_EN
    logic         sgn = 1'b0;
`endif
    logic         busy, done, wb_write;
    logic [W-1:0] result;
    logic [S-1:0] wb_sel;

    mul_div_unit #(.WIDTH(W), .SEL_W(S)) dut (
        .clk(clk), .rst(rst), .EN(EN), .start(start), .op(op),
        .opA(opA), .opB(opB), .dest(dest),
`ifdef SIGNED_OP_EN
        .sgn(sgn),
`endif
        .busy(busy), .done(done), .result(result),
        .wb_sel(wb_sel), .wb_write(wb_write)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        p = 64'(a) * 64'(b);
        case (o)
            2'b00: r = p[31:0];
            2'b01: r = p[63:32];
            2'b10: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one op and follow it to completion, scrambling the operand
    // inputs after accept since they are don't-care from then on.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic [31:0] er, input int el,
                          input string tag);
        int n, stray;
        op = o; opA = a; opB = b; dest = d; start = 1'b1;
        tick();
        start = 1'b0;
        opA = $urandom; opB = $urandom; op = 2'($urandom); dest = 5'($urandom);
        chk({tag, " busy_after_accept"}, 64'(busy), 64'(1));
        n = 0; stray = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1 || wb_write !== 1'b0) stray++;
            tick();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(el));
        chk({tag, " stray_ctl"}, 64'(stray), 64'(0));
        chk({tag, " result"}, 64'(result), 64'(er));
        chk({tag, " wb_write"}, 64'(wb_write), 64'(d != 0));
        chk({tag, " wb_sel"}, 64'(wb_sel), 64'(d));
        chk({tag, " busy_at_done"}, 64'(busy), 64'(1));
        tick();
        chk({tag, " done_falls"}, 64'({done, busy, wb_write}), 64'(0));
        chk({tag, " result_hold"}, 64'(result), 64'(er));
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [4:0]  d;
        logic [31:0] er;
        int          el;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n, cnt;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [4:0]  rd;

        vecs[0] = '{2'b00, 32'd7,          32'd6,          5'd3,  32'd42,         33};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'hFFFF_FFFE,  33};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'h0000_0001,  33};
        vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd5,  32'd14,         33};
        vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd0,  32'd2,          33};
        vecs[5] = '{2'b10, 32'd5,          32'd0,          5'd6,  32'hFFFF_FFFF,  1};
        vecs[6] = '{2'b11, 32'd5,          32'd0,          5'd7,  32'd5,          1};
        vecs[7] = '{2'b01, 32'h8000_0000,  32'd2,          5'd31, 32'd1,          33};
        vecs[8] = '{2'b10, 32'hFFFF_FFFF,  32'd1,          5'd1,  32'hFFFF_FFFF,  33};
        vecs[9] = '{2'b11, 32'd7,          32'd100,        5'd2,  32'd7,          33};

        rst = 1'b1; EN = 1'b1; start = 1'b0; op = '0; opA = '0; opB = '0; dest = '0;
        tick(); tick();
        chk("reset_ctl", 64'({busy, done, wb_write}), 64'(0));
        chk("reset_result", 64'(result), 64'(0));
        chk("reset_wb_sel", 64'(wb_sel), 64'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].er, vecs[i].el,
                   $sformatf("vec%0d", i));

        // Result persists through idle cycles.
        repeat (5) tick();
        chk("idle_hold", 64'(result), 64'(32'd7));

        // Second start mid-run is ignored.
        op = 2'b00; opA = 32'd7; opB = 32'd6; dest = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        op = 2'b10; opA = 32'd100; opB = 32'd0; dest = 5'd9; start = 1'b1;
        tick();
        start = 1'b0;
        n = 10;
        while (done !== 1'b1 && n < 100) begin tick(); n++; end
        chk("retrig latency", 64'(n), 64'(33));
        chk("retrig result", 64'(result), 64'(32'd42));
        chk("retrig wb_sel", 64'(wb_sel), 64'(5'd3));
        cnt = 0;
        repeat (40) begin tick(); if (done === 1'b1) cnt++; end
        chk("retrig single_done", 64'(cnt), 64'(0));

        // EN low for 4 cycles mid-run, then EN low while in DONE.
        op = 2'b10; opA = 32'd1000; opB = 32'd9; dest = 5'd12; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        EN = 1'b0;
        cnt = 0;
        repeat (4) begin tick(); if (busy !== 1'b1 || done !== 1'b0) cnt++; end
        chk("stall held", 64'(cnt), 64'(0));
        EN = 1'b1;
        n = 14;
        while (done !== 1'b1 && n < 100) begin tick(); n++; end
        chk("stall latency", 64'(n), 64'(37));
        chk("stall result", 64'(result), 64'(32'd111));
        EN = 1'b0;
        tick(); tick();
        chk("done_stall ctl", 64'({done, wb_write, busy}), 64'(3'b111));
        chk("done_stall result", 64'(result), 64'(32'd111));
        EN = 1'b1;
        tick();
        chk("done_stall release", 64'({done, wb_write, busy}), 64'(0));

        // Reset mid-divide aborts with no write-back.
        op = 2'b10; opA = 32'd100; opB = 32'd7; dest = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort ctl", 64'({busy, done, wb_write}), 64'(0));
        chk("abort result", 64'(result), 64'(0));
        chk("abort wb_sel", 64'(wb_sel), 64'(0));
        run_op(2'b11, 32'd100, 32'd7, 5'd9, 32'd2, 33, "post_abort");

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            rd = 5'($urandom);
            run_op(ro, ra, rb, rd, model(ro, ra, rb), (ro[1] && rb == 0) ? 1 : 33,
                   $sformatf("rnd%0d op%0d", i, ro));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
